// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads the async instruction memory and queues
// {instr, pc} pairs for decode. Optional macro: JUMP_PREDECODE_EN.
module imem_fetch_ctrl #(
    parameter int                 ADDR_W   = 7,
    parameter int                 DEPTH    = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt_req,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Handshake: a head entry transfers on any rising edge where if_valid and
    // if_ready are both high; if_instr/if_pc stay put while if_valid && !if_ready.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] LAST_PTR = 2'(DEPTH - 1);
    localparam logic [2:0] FULL_CNT = 3'(DEPTH);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_pc_seq;
    logic [ADDR_W-1:0] w_pc_fetch;
    logic [2:0]        r_count;
    logic [1:0]        r_head;
    logic [1:0]        r_tail;
    logic [31:0]       r_buf_instr [0:3];
    logic [ADDR_W-1:0] r_buf_pc    [0:3];
    logic              w_push;
    logic              w_pop;
    logic              w_valid;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
    endfunction

    assign w_valid  = (r_count != 3'd0);
    // Redirect flushes the buffer, so it suppresses both push and pop.
    assign w_push   = (r_state == ST_RUN) && (r_count != FULL_CNT) && !redirect_valid;
    assign w_pop    = w_valid && if_ready && !redirect_valid;
    assign w_pc_seq = r_pc + ADDR_W'(4);

`ifdef JUMP_PREDECODE_EN
    assign w_pc_fetch = (imem_data[31:26] == 6'b000010) ?
                        {imem_data[ADDR_W-3:0], 2'b00} : w_pc_seq;
`else
    assign w_pc_fetch = w_pc_seq;
`endif

    always_comb begin
        w_pc_next = r_pc;
        if (redirect_valid) begin
            w_pc_next = {redirect_pc[ADDR_W-1:2], 2'b00};
        end else if ((r_state == ST_IDLE) && start) begin
            w_pc_next = RESET_PC;
        end else if (w_push) begin
            w_pc_next = w_pc_fetch;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start)    w_state_next = ST_RUN;
            ST_RUN:   if (halt_req) w_state_next = ST_DRAIN;
            // Exit is judged on the pre-edge count, so a redirect flush in
            // DRAIN leaves one extra cycle before returning to IDLE.
            ST_DRAIN: if (r_count == 3'd0) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 3'd0;
            r_head  <= 2'd0;
            r_tail  <= 2'd0;
        end else if (redirect_valid) begin
            r_count <= 3'd0;
            r_head  <= 2'd0;
            r_tail  <= 2'd0;
        end else begin
            if (w_pop)  r_head <= ptr_inc(r_head);
            if (w_push) r_tail <= ptr_inc(r_tail);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_buf_instr[i] <= '0;
                r_buf_pc[i]    <= '0;
            end
        end else if (w_push) begin
            r_buf_instr[r_tail] <= imem_data;
            r_buf_pc[r_tail]    <= r_pc;
        end
    end

    assign imem_addr = r_pc;
    assign if_valid  = w_valid;
    assign if_instr  = w_valid ? r_buf_instr[r_head] : 32'd0;
    assign if_pc     = w_valid ? r_buf_pc[r_head] : '0;
    assign busy      = (r_state != ST_IDLE) || w_valid;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed vector table, mid-run reset, and random
// stimulus checked against a queue-based reference model.
module tb_imem_fetch_ctrl;

    localparam int          ADDR_W   = 7;
    localparam int          DEPTH    = 2;
    localparam logic [6:0]  RESET_PC = 7'h00;
`ifdef JUMP_PREDECODE_EN
    localparam bit          JMP = 1'b1;
`else
    localparam bit          JMP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [6:0]  redirect_pc = '0;
    logic [6:0]  imem_addr;
    logic [31:0] imem_data;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [6:0]  if_pc;
    logic        busy;
    logic [1:0]  dbg_state;

    logic [31:0] mem [0:31];
    assign imem_data = mem[imem_addr[6:2]];

    always #5 clk = ~clk;

    imem_fetch_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_data(imem_data), .if_valid(if_valid),
        .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .busy(busy), .dbg_state(dbg_state)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit          rst;
        bit          start;
        bit          halt;
        bit          redir;
        logic [6:0]  rpc;
        bit          ready;
        bit          e_valid;
        logic [6:0]  e_pc;
        logic [31:0] e_instr;
        logic [6:0]  e_addr;
        bit          e_busy;
    } vec_t;
    vec_t vecs[$];

    typedef struct packed {
        logic [31:0] instr;
        logic [6:0]  pc;
    } ent_t;
    ent_t m_q[$];
    int   m_pc;
    int   m_mode;   // 0 idle, 1 run, 2 drain

    function automatic void add(input bit r, input bit s, input bit h, input bit rd,
                                input logic [6:0] rp, input bit rdy, input bit ev,
                                input logic [6:0] epc, input logic [31:0] ei,
                                input logic [6:0] ea, input bit eb);
        vec_t v;
        v.rst = r; v.start = s; v.halt = h; v.redir = rd; v.rpc = rp; v.ready = rdy;
        v.e_valid = ev; v.e_pc = epc; v.e_instr = ei; v.e_addr = ea; v.e_busy = eb;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input bit ev, input logic [6:0] epc,
                         input logic [31:0] ei, input logic [6:0] ea, input bit eb);
        n_vec++;
        if (if_valid !== ev || if_pc !== epc || if_instr !== ei ||
            imem_addr !== ea || busy !== eb) begin
            n_bad++;
            $display("FAIL %s: got valid=%0b pc=%h instr=%h addr=%h busy=%0b; want valid=%0b pc=%h instr=%h addr=%h busy=%0b",
                     name, if_valid, if_pc, if_instr, imem_addr, busy, ev, epc, ei, ea, eb);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; if_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_q.delete();
        m_pc = int'(RESET_PC);
        m_mode = 0;
    endtask

    task automatic model_step(input bit st, input bit hl, input bit rd,
                              input logic [6:0] rp, input bit rdy);
        int n;
        int npc;
        logic [31:0] w;
        n = m_q.size();
        npc = m_pc;
        if (rd) begin
            m_q.delete();
            npc = int'(rp) & 32'h7C;
        end else begin
            if (n > 0 && rdy) void'(m_q.pop_front());
            if (m_mode == 1 && n < DEPTH) begin
                w = mem[m_pc / 4];
                m_q.push_back({w, 7'(m_pc)});
                npc = (m_pc + 4) % 128;
                if (JMP && w[31:26] == 6'b000010) npc = int'(w % 32'd32) * 4;
            end
        end
        case (m_mode)
            0: if (st) begin m_mode = 1; if (!rd) npc = int'(RESET_PC); end
            1: if (hl) m_mode = 2;
            default: if (n == 0) m_mode = 0;
        endcase
        m_pc = npc;
    endtask

    localparam logic [31:0] M0 = 32'h2008_0001;
    localparam logic [31:0] M1 = 32'h8C09_0004;
    localparam logic [31:0] M2 = 32'h0109_4020;
    localparam logic [31:0] M3 = 32'h2008_0003;
    localparam logic [31:0] M4 = 32'h0800_0003;
    localparam logic [31:0] M5 = 32'h2008_0002;

    initial begin
        bit s, h, rd, rdy;
        logic [6:0] rp;
        for (int i = 0; i < 32; i++) mem[i] = 32'h2008_0000 | i;
        mem[0] = M0; mem[1] = M1; mem[2] = M2; mem[3] = M3; mem[4] = M4; mem[5] = M5;

        // basic start latency and streaming
        add(1,1,0,0,0,1, 0,7'h00,0,7'h00,0);
        add(0,0,0,0,0,1, 0,7'h00,0,7'h00,1);
        add(0,0,0,0,0,1, 1,7'h00,M0,7'h04,1);
        add(0,0,0,0,0,1, 1,7'h04,M1,7'h08,1);
        add(0,0,0,0,0,1, 1,7'h08,M2,7'h0C,1);
        // backpressure fills buffer, release without gap or duplicate
        add(1,1,0,0,0,0, 0,7'h00,0,7'h00,0);
        add(0,0,0,0,0,0, 0,7'h00,0,7'h00,1);
        add(0,0,0,0,0,0, 1,7'h00,M0,7'h04,1);
        add(0,0,0,0,0,0, 1,7'h00,M0,7'h08,1);
        add(0,0,0,0,0,0, 1,7'h00,M0,7'h08,1);
        add(0,0,0,0,0,1, 1,7'h00,M0,7'h08,1);
        add(0,0,0,0,0,1, 1,7'h04,M1,7'h08,1);
        add(0,0,0,0,0,1, 1,7'h08,M2,7'h0C,1);
        add(0,0,0,0,0,1, 1,7'h0C,M3,7'h10,1);
        // redirect on full buffer, low bits masked
        add(1,1,0,0,0,0, 0,7'h00,0,7'h00,0);
        add(0,0,0,0,0,0, 0,7'h00,0,7'h00,1);
        add(0,0,0,0,0,0, 1,7'h00,M0,7'h04,1);
        add(0,0,0,0,0,0, 1,7'h00,M0,7'h08,1);
        add(0,0,0,1,7'h15,1, 1,7'h00,M0,7'h08,1);
        add(0,0,0,0,0,1, 0,7'h00,0,7'h14,1);
        add(0,0,0,0,0,1, 1,7'h14,M5,7'h18,1);
        add(0,0,0,0,0,1, 1,7'h18,32'h2008_0006,7'h1C,1);
        // PC wrap
        add(1,1,0,0,0,1, 0,7'h00,0,7'h00,0);
        add(0,0,0,1,7'h7C,1, 0,7'h00,0,7'h00,1);
        add(0,0,0,0,0,1, 0,7'h00,0,7'h7C,1);
        add(0,0,0,0,0,1, 1,7'h7C,32'h2008_001F,7'h00,1);
        add(0,0,0,0,0,1, 1,7'h00,M0,7'h04,1);
        // halt with two buffered, drain, restart from RESET_PC
        add(1,1,0,0,0,0, 0,7'h00,0,7'h00,0);
        add(0,0,0,0,0,0, 0,7'h00,0,7'h00,1);
        add(0,0,0,0,0,0, 1,7'h00,M0,7'h04,1);
        add(0,0,1,0,0,0, 1,7'h00,M0,7'h08,1);
        add(0,0,0,0,0,1, 1,7'h00,M0,7'h08,1);
        add(0,0,0,0,0,1, 1,7'h04,M1,7'h08,1);
        add(0,0,0,0,0,1, 0,7'h00,0,7'h08,1);
        add(0,1,0,0,0,1, 0,7'h00,0,7'h08,0);
        add(0,0,0,0,0,1, 0,7'h00,0,7'h00,1);
        add(0,0,0,0,0,1, 1,7'h00,M0,7'h04,1);
        // jump word at 0x10
        add(1,1,0,0,0,1, 0,7'h00,0,7'h00,0);
        add(0,0,0,0,0,1, 0,7'h00,0,7'h00,1);
        add(0,0,0,0,0,1, 1,7'h00,M0,7'h04,1);
        add(0,0,0,0,0,1, 1,7'h04,M1,7'h08,1);
        add(0,0,0,0,0,1, 1,7'h08,M2,7'h0C,1);
        add(0,0,0,0,0,1, 1,7'h0C,M3,7'h10,1);
        add(0,0,0,0,0,1, 1,7'h10,M4,JMP ? 7'h0C : 7'h14,1);
        add(0,0,0,0,0,1, 1,JMP ? 7'h0C : 7'h14,JMP ? M3 : M5,JMP ? 7'h10 : 7'h18,1);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            start = vecs[i].start; halt_req = vecs[i].halt;
            redirect_valid = vecs[i].redir; redirect_pc = vecs[i].rpc;
            if_ready = vecs[i].ready;
            #1;
            check($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc,
                  vecs[i].e_instr, vecs[i].e_addr, vecs[i].e_busy);
            @(negedge clk);
        end

        // asynchronous reset in the middle of a run
        do_reset();
        start = 1'b1; if_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset", 1'b0, 7'h00, 32'd0, RESET_PC, 1'b0);
        n_vec++;
        if (dbg_state !== 2'd0) begin
            n_bad++;
            $display("FAIL async_reset_state: got %0d want 0", dbg_state);
        end

        // random stimulus against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            s   = ($urandom_range(0, 9) == 0);
            h   = ($urandom_range(0, 29) == 0);
            rd  = ($urandom_range(0, 19) == 0);
            rp  = 7'($urandom_range(0, 127));
            rdy = ($urandom_range(0, 9) < 7);
            start = s; halt_req = h; redirect_valid = rd; redirect_pc = rp; if_ready = rdy;
            #1;
            if (m_q.size() > 0)
                check($sformatf("rand%0d", c), 1'b1, m_q[0].pc, m_q[0].instr,
                      7'(m_pc), 1'b1);
            else
                check($sformatf("rand%0d", c), 1'b0, 7'h00, 32'd0, 7'(m_pc), m_mode != 0);
            model_step(s, h, rd, rp, rdy);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
